// File: rtl/xbar_mem_slave.sv
// Word-addressed RAM responder that terminates one crossbar slave port.
// Handles one request at a time and acks it after WAIT_CYCLES idle cycles.
`timescale 1ns/1ps
module xbar_mem_slave #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  slave_req,
   input  logic [ADDR_WIDTH-1:0] slave_addr,
   input  logic                  slave_cmd,
   input  logic [DATA_WIDTH-1:0] slave_wdata,
   output logic                  slave_ack,
   output logic [DATA_WIDTH-1:0] slave_rdata,
   output logic                  busy
);

   localparam int IW = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  cmd_q, cmd_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // Byte-lane bits and bits above the word index are deliberately dropped,
   // so addresses alias modulo MEM_DEPTH*4.
   logic unused_addr;
   assign unused_addr = ^{slave_addr[ADDR_WIDTH-1:IW+2], slave_addr[1:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      cmd_d   = cmd_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (slave_req) begin
               idx_d   = slave_addr[IW+1:2];
               cmd_d   = slave_cmd;
               wdata_d = slave_wdata;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_ACK;
               end else begin
                  cnt_d   = 8'(WAIT_CYCLES);
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q <= 8'd1) state_d = S_ACK;
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Read data is latched on entry to ACK; a write in ACK commits at the
      // same edge that leaves ACK, so a following read always sees it.
      if (state_d == S_ACK && state_q != S_ACK && !cmd_d) begin
         rdata_d = mem[idx_d];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         cmd_q   <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         cmd_q   <= cmd_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == S_ACK && cmd_q) begin
         mem[idx_q] <= wdata_q;
      end
   end

   assign slave_ack   = (state_q == S_ACK);
   assign busy        = (state_q != S_IDLE);
   assign slave_rdata = rdata_q;

endmodule

// File: tb/tb_xbar_mem_slave.sv
// Directed bench for xbar_mem_slave: one instance with two wait states and
// one with none, driven from a vector table plus hand-written corner cases.
`timescale 1ns/1ps
module tb_xbar_mem_slave;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        a_req, a_cmd, a_ack, a_busy;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic        b_req, b_cmd, b_ack, b_busy;
   logic [31:0] b_addr, b_wdata, b_rdata;

   xbar_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_CYCLES(2)) u_a (
      .clk(clk), .rst(rst), .slave_req(a_req), .slave_addr(a_addr), .slave_cmd(a_cmd),
      .slave_wdata(a_wdata), .slave_ack(a_ack), .slave_rdata(a_rdata), .busy(a_busy));

   xbar_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_CYCLES(0)) u_b (
      .clk(clk), .rst(rst), .slave_req(b_req), .slave_addr(b_addr), .slave_cmd(b_cmd),
      .slave_wdata(b_wdata), .slave_ack(b_ack), .slave_rdata(b_rdata), .busy(b_busy));

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_rd = 32'h0;

   // mode: 0 normal, 1 change addr/cmd/wdata during WAIT, 2 drop req during WAIT
   typedef struct {
      logic        cmd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      int          mode;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic txn_a(input logic cmd, input logic [31:0] addr, input logic [31:0] wdata,
                        input int mode);
      int          k;
      logic        seen;
      logic [31:0] exp;
      @(posedge clk); #1;
      a_req = 1'b1; a_cmd = cmd; a_addr = addr; a_wdata = wdata;
      @(posedge clk);
      k = 0;
      seen = 1'b0;
      while (!seen && k < 20) begin
         @(negedge clk);
         if (a_ack) begin
            seen = 1'b1;
         end else begin
            chk("a_busy_wait", 32'(a_busy), 32'h1);
            if (mode == 1) begin
               a_addr = addr ^ 32'h4; a_wdata = ~wdata; a_cmd = ~cmd;
            end
            if (mode == 2) a_req = 1'b0;
            k++;
         end
      end
      a_req = 1'b0;
      chk("a_ack_seen", 32'(seen), 32'h1);
      chk("a_latency", 32'(k), 32'd2);
      chk("a_busy_ack", 32'(a_busy), 32'h1);
      if (!cmd) begin
         exp = exp_q.pop_front();
         chk("a_rdata_ack", a_rdata, exp);
         last_rd = exp;
      end
      @(negedge clk);
      chk("a_ack_pulse", 32'(a_ack), 32'h0);
      chk("a_rdata_hold", a_rdata, last_rd);
      chk("a_busy_idle", 32'(a_busy), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic prev;
      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0};
      vecs[2]  = '{1'b1, 32'h0000_0004, 32'h1,         32'h0,         0};
      vecs[3]  = '{1'b0, 32'h0000_0404, 32'h0,         32'h1,         0};
      vecs[4]  = '{1'b0, 32'h0000_0007, 32'h0,         32'h1,         0};
      vecs[5]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,         0};
      vecs[6]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'hCAFE_F00D, 0};
      vecs[7]  = '{1'b1, 32'h0000_0034, 32'h0,         32'h0,         0};
      vecs[8]  = '{1'b1, 32'h0000_0030, 32'hAAAA_0001, 32'h0,         1};
      vecs[9]  = '{1'b0, 32'h0000_0030, 32'h0,         32'hAAAA_0001, 0};
      vecs[10] = '{1'b0, 32'h0000_0034, 32'h0,         32'h0,         0};
      vecs[11] = '{1'b1, 32'h0000_0040, 32'h55,        32'h0,         2};
      vecs[12] = '{1'b0, 32'h0000_0040, 32'h0,         32'h55,        0};
      vecs[13] = '{1'b1, 32'h0000_0014, 32'h77,        32'h0,         0};

      rst = 1'b1;
      a_req = 1'b0; a_cmd = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_cmd = 1'b0; b_addr = '0; b_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_a_ack",   32'(a_ack),  32'h0);
      chk("rst_a_rdata", a_rdata,     32'h0);
      chk("rst_a_busy",  32'(a_busy), 32'h0);
      chk("rst_b_ack",   32'(b_ack),  32'h0);
      chk("rst_b_rdata", b_rdata,     32'h0);
      chk("rst_b_busy",  32'(b_busy), 32'h0);

      for (int i = 0; i < 14; i++) begin
         if (!vecs[i].cmd) exp_q.push_back(vecs[i].exp);
         txn_a(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].mode);
      end

      // Reset during WAIT of a write to index 5 (which holds 0x77).
      @(posedge clk); #1;
      a_req = 1'b1; a_cmd = 1'b1; a_addr = 32'h14; a_wdata = 32'h1234;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_busy_before", 32'(a_busy), 32'h1);
      rst = 1'b1;
      #1;
      chk("midrst_busy_now", 32'(a_busy), 32'h0);
      chk("midrst_ack_now",  32'(a_ack),  32'h0);
      chk("midrst_rdata",    a_rdata,     32'h0);
      a_req = 1'b0;
      last_rd = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("midrst_no_ack", 32'(a_ack), 32'h0);
      end
      exp_q.push_back(32'h77);
      txn_a(1'b0, 32'h14, 32'h0, 0);

      // Zero wait states, req held high: alternating writes to index 3, then a read.
      @(posedge clk); #1;
      b_req = 1'b1; b_cmd = 1'b1; b_addr = 32'hC; b_wdata = 32'hA5;
      @(posedge clk);
      prev = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("b_ack_pattern", 32'(b_ack), 32'((i % 2) == 0));
         chk("b_no_consec",   32'(prev & b_ack), 32'h0);
         prev = b_ack;
         if (i == 6) b_cmd = 1'b0;
         else if (b_ack && b_cmd) b_wdata = (b_wdata == 32'hA5) ? 32'h5A : 32'hA5;
         if (i == 8) begin
            chk("b_rdata_last_write", b_rdata, 32'h5A);
            b_req = 1'b0;
         end
      end
      @(negedge clk);
      chk("b_ack_after",   32'(b_ack), 32'h0);
      chk("b_rdata_hold",  b_rdata,    32'h5A);
      chk("b_busy_idle",   32'(b_busy), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
